// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_if
//  Description : Core-facing bus of the interrupt controller: acknowledge,
//                end-of-interrupt, mask configuration and the registered
//                request / interrupt-number outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface irq_ctrl_if #(
    parameter int NUM_IRQ = 8
);
    logic               I_irq_ack;
    logic               I_eoi;
    logic               I_cfg_write;
    logic [NUM_IRQ-1:0] I_cfg_data;
    logic               O_irq_active;
    logic               O_data_valid;
    logic [15:0]        O_data;
    logic [NUM_IRQ-1:0] O_mask;
    logic [NUM_IRQ-1:0] O_pending;

    // Core / configuration side
    modport master (
        output I_irq_ack, I_eoi, I_cfg_write, I_cfg_data,
        input  O_irq_active, O_data_valid, O_data, O_mask, O_pending
    );

    // Interrupt controller side
    modport slave (
        input  I_irq_ack, I_eoi, I_cfg_write, I_cfg_data,
        output O_irq_active, O_data_valid, O_data, O_mask, O_pending
    );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : Fixed-priority interrupt controller. Synchronises and
//                edge-detects up to 16 sources, latches them as pending,
//                masks, arbitrates (lowest index wins), requests the core,
//                delivers the number for one cycle after acknowledge and
//                waits for end-of-interrupt before the next request.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_ctrl #(
    parameter int                 NUM_IRQ    = 8,
    parameter logic [NUM_IRQ-1:0] MASK_RESET = {NUM_IRQ{1'b1}}
) (
    input  wire logic               I_clk,
    input  wire logic               I_reset,
    input  wire logic [NUM_IRQ-1:0] I_irq,
    irq_ctrl_if.slave               bus
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ACTIVE    = 2'd1;
    localparam logic [1:0] c_DATA      = 2'd2;
    localparam logic [1:0] c_INSERVICE = 2'd3;

    logic [NUM_IRQ-1:0] r_s1, r_s2, r_s3, r_rise;
    logic [NUM_IRQ-1:0] r_pend, r_mask;
    logic               r_ack_d;
    logic [1:0]         r_state;
    logic [3:0]         r_num;
    logic               r_active, r_valid;
    logic [15:0]        r_data;

    logic [NUM_IRQ-1:0] w_req, w_clr;
    logic [3:0]         w_win;
    logic               w_ack_rise, w_latch, w_take;
    logic [1:0]         w_state_nxt;
    logic               w_active_nxt, w_valid_nxt;
    logic [15:0]        w_data_nxt;

    assign w_req      = r_pend & r_mask;
    assign w_ack_rise = bus.I_irq_ack & ~r_ack_d;

    // Synchroniser chain; the rise pulse is registered so a source edge
    // becomes pending three edges after it is first sampled.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_rise  <= '0;
            r_ack_d <= 1'b0;
        end else begin
            r_s1    <= I_irq;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_rise  <= r_s2 & ~r_s3;
            r_ack_d <= bus.I_irq_ack;
        end
    end

    // Priority encoder: scanning downwards leaves the lowest set index.
    always_comb begin
        w_win = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) w_win = 4'(i);
        end
    end

    // Acknowledged source clear; wins over a rise arriving the same cycle.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = w_take && (r_num == 4'(i));
        end
    end

    // Pending and mask registers.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            r_pend <= '0;
            r_mask <= MASK_RESET;
        end else begin
            r_pend <= (r_pend | r_rise) & ~w_clr;
            if (bus.I_cfg_write) r_mask <= bus.I_cfg_data;
        end
    end

    // Next-state and next-output logic for the delivery sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_valid_nxt  = 1'b0;
        w_data_nxt   = 16'd0;
        w_latch      = 1'b0;
        w_take       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (|w_req) begin
                    w_latch      = 1'b1;
                    w_active_nxt = 1'b1;
                    w_state_nxt  = c_ACTIVE;
                end
            end
            c_ACTIVE: begin
                if (w_ack_rise) begin
                    w_take       = 1'b1;
                    w_active_nxt = 1'b0;
                    w_valid_nxt  = 1'b1;
                    w_data_nxt   = {12'd0, r_num};
                    w_state_nxt  = c_DATA;
                end
            end
            c_DATA: begin
                w_state_nxt = c_INSERVICE;
            end
            default: begin
                if (bus.I_eoi) w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State register and registered core-facing outputs.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            r_state  <= c_IDLE;
            r_num    <= 4'd0;
            r_active <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= 16'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_valid  <= w_valid_nxt;
            r_data   <= w_data_nxt;
            if (w_latch) r_num <= w_win;
        end
    end

    assign bus.O_irq_active = r_active;
    assign bus.O_data_valid = r_valid;
    assign bus.O_data       = r_data;
    assign bus.O_mask       = r_mask;
    assign bus.O_pending    = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_ctrl
//  Description : Self-checking bench for irq_ctrl with a phase-level
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq;

    irq_ctrl_if #(.NUM_IRQ(8)) bus ();

    irq_ctrl #(.NUM_IRQ(8), .MASK_RESET(8'hFF)) dut (
        .I_clk   (clk),
        .I_reset (rst_n),
        .I_irq   (irq),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 requesting, 2 delivering, 3 in service.
    int         m_phase;
    int         m_num;
    logic [7:0] m_pend, m_mask, m_rise, m_next_pend, m_req;
    logic       m_ack_prev;
    logic [7:0] hist [5];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase    = 0;
            m_num      = 0;
            m_pend     = 8'h00;
            m_mask     = 8'hFF;
            m_ack_prev = 1'b0;
            for (int i = 0; i < 5; i++) hist[i] = 8'h00;
        end else begin
            // An edge first sampled at edge n lands in pending at edge n+3.
            for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = irq;
            m_rise = hist[3] & ~hist[4];
            m_next_pend = m_pend | m_rise;
            m_req = m_pend & m_mask;
            case (m_phase)
                0: if (m_req != 0) begin
                    for (int i = 7; i >= 0; i--) if (m_req[i]) m_num = i;
                    m_phase = 1;
                end
                1: if (bus.I_irq_ack && !m_ack_prev) begin
                    m_next_pend[m_num] = 1'b0;
                    m_phase = 2;
                end
                2: m_phase = 3;
                default: if (bus.I_eoi) m_phase = 0;
            endcase
            m_pend = m_next_pend;
            if (bus.I_cfg_write) m_mask = bus.I_cfg_data;
            m_ack_prev = bus.I_irq_ack;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                check("rst_active", {31'd0, bus.O_irq_active}, 32'd0);
                check("rst_valid",  {31'd0, bus.O_data_valid}, 32'd0);
                check("rst_pend",   {24'd0, bus.O_pending}, 32'd0);
            end else begin
                check("m_active",  {31'd0, bus.O_irq_active}, {31'd0, m_phase == 1});
                check("m_valid",   {31'd0, bus.O_data_valid}, {31'd0, m_phase == 2});
                check("m_data",    {16'd0, bus.O_data}, (m_phase == 2) ? m_num : 32'd0);
                check("m_pending", {24'd0, bus.O_pending}, {24'd0, m_pend});
                check("m_mask",    {24'd0, bus.O_mask}, {24'd0, m_mask});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq = irq | m;
        tick(1);
        irq = irq & ~m;
    endtask

    task automatic wait_active();
        int n;
        n = 0;
        while (!bus.O_irq_active && n < 30) begin
            tick(1);
            n++;
        end
        check("wait_active", {31'd0, bus.O_irq_active}, 32'd1);
    endtask

    task automatic deliver(input logic [15:0] exp);
        bus.I_irq_ack = 1'b1;
        tick(1);
        check("ack_valid", {31'd0, bus.O_data_valid}, 32'd1);
        check("ack_data",  {16'd0, bus.O_data}, {16'd0, exp});
        check("ack_drop",  {31'd0, bus.O_irq_active}, 32'd0);
        bus.I_irq_ack = 1'b0;
        tick(1);
        check("data_end", {31'd0, bus.O_data_valid}, 32'd0);
    endtask

    task automatic send_eoi();
        bus.I_eoi = 1'b1;
        tick(1);
        bus.I_eoi = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.I_cfg_write = 1'b1;
        bus.I_cfg_data  = m;
        tick(1);
        bus.I_cfg_write = 1'b0;
    endtask

    int vcount;

    initial begin
        rst_n = 1'b0;
        irq = 8'h00;
        bus.I_irq_ack = 1'b0;
        bus.I_eoi = 1'b0;
        bus.I_cfg_write = 1'b0;
        bus.I_cfg_data = 8'h00;
        tick(3);
        chk_en = 1;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("reset_mask", {24'd0, bus.O_mask}, 32'hFF);
        check("reset_data", {16'd0, bus.O_data}, 32'd0);

        // Source latency: request exactly four edges after the sampled rise.
        irq = 8'h08;
        tick(4);
        irq = 8'h00;
        check("lat_pend3", {24'd0, bus.O_pending}, 32'h08);
        check("lat_early", {31'd0, bus.O_irq_active}, 32'd0);
        tick(1);
        check("lat_active", {31'd0, bus.O_irq_active}, 32'd1);
        deliver(16'h0003);
        check("pend3_clr", {24'd0, bus.O_pending}, 32'h00);
        send_eoi();

        // Simultaneous rises: 2 before 5; re-request one cycle after EOI.
        pulse_irq(8'h24);
        wait_active();
        deliver(16'h0002);
        tick(2);
        bus.I_eoi = 1'b1;
        tick(1);
        bus.I_eoi = 1'b0;
        check("eoi_edge", {31'd0, bus.O_irq_active}, 32'd0);
        tick(1);
        check("eoi_next", {31'd0, bus.O_irq_active}, 32'd1);
        deliver(16'h0005);
        send_eoi();

        // Masked pending bit fires once the mask opens.
        write_mask(8'hFE);
        pulse_irq(8'h01);
        tick(6);
        check("masked_pend", {24'd0, bus.O_pending}, 32'h01);
        check("masked_idle", {31'd0, bus.O_irq_active}, 32'd0);
        bus.I_cfg_write = 1'b1;
        bus.I_cfg_data  = 8'hFF;
        tick(1);
        bus.I_cfg_write = 1'b0;
        check("unmask_e1", {31'd0, bus.O_irq_active}, 32'd0);
        tick(1);
        check("unmask_e2", {31'd0, bus.O_irq_active}, 32'd1);
        deliver(16'h0000);
        send_eoi();

        // Held ack gives one delivery; source 1 waits through service of 4.
        pulse_irq(8'h10);
        wait_active();
        bus.I_irq_ack = 1'b1;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (i == 1) irq = 8'h02;
            if (i == 2) irq = 8'h00;
            if (bus.O_data_valid) vcount++;
        end
        bus.I_irq_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus.O_data_valid) vcount++;
        end
        check("held_ack_pulses", vcount, 32'd1);
        check("insvc_pend1", {24'd0, bus.O_pending}, 32'h02);
        check("insvc_quiet", {31'd0, bus.O_irq_active}, 32'd0);
        send_eoi();
        wait_active();
        deliver(16'h0001);
        send_eoi();

        // Reset while the number is on the bus.
        pulse_irq(8'h40);
        wait_active();
        pulse_irq(8'h80);
        tick(4);
        bus.I_irq_ack = 1'b1;
        tick(1);
        check("pre_rst_valid", {31'd0, bus.O_data_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, bus.O_data_valid}, 32'd0);
        check("async_data",  {16'd0, bus.O_data}, 32'd0);
        check("async_pend",  {24'd0, bus.O_pending}, 32'd0);
        bus.I_irq_ack = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_mask", {24'd0, bus.O_mask}, 32'hFF);
        check("post_rst_idle", {31'd0, bus.O_irq_active}, 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            irq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : irq;
            bus.I_irq_ack = ($urandom_range(0, 2) == 0);
            bus.I_eoi = ($urandom_range(0, 4) == 0);
            bus.I_cfg_write = ($urandom_range(0, 19) == 0);
            bus.I_cfg_data = 8'($urandom) | 8'h81;
            tick(1);
        end
        irq = 8'h00;
        bus.I_irq_ack = 1'b0;
        bus.I_eoi = 1'b0;
        bus.I_cfg_write = 1'b0;
        tick(5);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller that sits directly upstream of the CPU core. It synchronises and latches up to 16 external interrupt sources, masks them, and arbitrates them by fixed priority. It raises the core's interrupt request and, after the core acknowledges, drives the winning interrupt number onto the core's data-in bus for exactly one cycle. It then holds off further requests until the ISR signals end-of-interrupt.

## Interface
Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..16); source 0 has highest priority.
- MASK_RESET, all ones (NUM_IRQ bits), reset value of the enable mask.

Ports:
- I_clk  in  1  system clock; all state updates on rising edge.
- I_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- I_irq  in  NUM_IRQ  raw interrupt sources, asynchronous, rising-edge triggered.
- I_irq_ack  in  1  acknowledge from core (core's O_irq_ack).
- I_eoi  in  1  end-of-interrupt pulse, issued when the core executes RETI.
- I_cfg_write  in  1  write enable for the mask register.
- I_cfg_data  in  NUM_IRQ  new mask value (1 = enabled).
- O_irq_active  out  1  interrupt request to core (core's I_irq_active); registered.
- O_data_valid  out  1  bus-driver enable: O_data is to be muxed onto the core's MEM_data_in.
- O_data  out  16  interrupt number, zero-extended; registered.
- O_mask  out  NUM_IRQ  current mask register.
- O_pending  out  NUM_IRQ  current pending register.

## Operation
- Synchroniser: each I_irq bit passes through two flops (s1, s2), plus a third flop (s3) for edge detection. A rising edge is s2 & ~s3.
- Pending: the bit is set on a detected rising edge. It is cleared only when that source is acknowledged. A repeated edge while pending is absorbed as a single event.
- Request vector: pending & mask. The winner is the lowest set index.
- FSM states:
  - IDLE: if the request vector is non-zero, latch the winner into num_r and go to ACTIVE, setting O_irq_active=1.
  - ACTIVE: on a rising edge of I_irq_ack (ack & ~ack_d), clear pending[num_r], set O_irq_active=0, O_data=num_r, O_data_valid=1, and go to DATA. A level-held ack does not re-trigger.
  - DATA: for one cycle only, set O_data_valid=0 and go to INSERVICE.
  - INSERVICE: on I_eoi=1, go to IDLE. No nesting; new requests wait.
- The winner is frozen at IDLE→ACTIVE. A higher-priority edge arriving during ACTIVE does not change num_r.
- Masking a source while ACTIVE does not withdraw the request; the committed interrupt is delivered.
- Mask write: at the next edge, mask <= I_cfg_data. The pending register is unaffected, so an unmasked pending bit fires later.
- Ignored events:
  - I_irq_ack outside ACTIVE.
  - I_eoi outside INSERVICE.
  - I_cfg_write in any state is always accepted.
- Simultaneous events:
  - An edge on num_r's source in the same cycle as ack: clear wins, then set re-applies at the next detected edge. A new edge after ack re-pends normally.
  - An edge on any other source is unaffected by ack.
- O_data is 0 whenever O_data_valid=0.

## Timing
- Reset (I_reset=0, async):
  - O_irq_active=0, O_data_valid=0, O_data=0.
  - pending=0, mask=MASK_RESET, sync flops=0, ack_d=0, state IDLE.
  - Reset mid-operation abandons any in-flight interrupt.
- Source latency: if I_irq rises before edge n, pending is visible after edge n+3 and O_irq_active=1 after edge n+4.
- Ack latency: I_irq_ack is sampled high at edge k (first high sample). After edge k, O_irq_active=0 and O_data_valid=1 with the number on O_data. The core captures it at edge k+1. After edge k+1, O_data_valid=0.
- EOI: I_eoi is sampled at edge m, giving IDLE after m. If a request is pending, O_irq_active=1 after edge m+1.
- Minimum spacing between two deliveries: ack, then 1 DATA cycle, then in-service until EOI, then 1 cycle.

## Test plan
- Reset, then pulse I_irq[3]: O_irq_active=1 exactly 4 edges later. Assert ack: the next cycle has O_data_valid=1, O_data=16'h0003, pending[3]=0.
- I_irq[5] and I_irq[2] rise in the same cycle: first delivery is 2. Send EOI: O_irq_active re-asserts 1 cycle later, and the second delivery is 5.
- Mask=8'hFE, pulse I_irq[0]: pending[0]=1 but no request. Then write mask=8'hFF: O_irq_active=1 after 2 edges, delivering 0.
- Hold I_irq_ack high for 5 cycles: exactly one O_data_valid pulse, and no second delivery before EOI even with pending[1] set.
- Pulse I_irq[1] during INSERVICE of 4: pending[1]=1 and O_irq_active stays 0 until EOI, then delivery is 1.
- Pull I_reset low during DATA: O_data_valid, O_data, and pending all go to 0 immediately. After release, the block is idle with mask=MASK_RESET.
